cycle_window_ctrl: RTL and testbench

Sequencer that runs timed measurement windows whose length comes from the user-programmed cycle configuration value (11-bit, reset 2047). On start it latches the configured length, holds `window_active` for exactly that many cycles, and counts qualifying events with a saturating counter. It then publishes the result through a registered read port of the same wen/ren/ready flavour as the other config registers. Sits between the cycle-config register and the datapath being measured.

---
 rtl/cycle_window_ctrl_pkg.sv | 16 +
 rtl/cycle_window_ctrl_if.sv | 11 +
 rtl/cycle_window_ctrl_sat_counter.sv | 46 ++++
 rtl/cycle_window_ctrl.sv | 120 ++++++++++++
 tb/tb_cycle_window_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cycle_window_ctrl_pkg.sv
// Shared widths, state encoding and limits for the measurement window sequencer.
package cycle_ctrl_pkg;

  localparam int CNT_W = 11;
  localparam int EVT_W = 16;

  localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } cyc_state_e;

endpackage

// File: rtl/cycle_window_ctrl_if.sv
// Result read port: same wen/ren/ready style as the other config registers.
interface cycle_window_ctrl_if #(
  parameter int EVT_W = 16
);
  logic             result_ren;
  logic [EVT_W-1:0] result_rdata;
  logic             result_ready;

  modport master (output result_ren, input result_rdata, input result_ready);
  modport slave  (input result_ren, output result_rdata, output result_ready);
endinterface

// File: rtl/cycle_window_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky flag that records
// any increment attempted while already at the maximum value.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  // Next count: clear wins, otherwise count up and stick at MAX.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (en) begin
      if (cnt_q == MAX) sat_d = 1'b1;
      else              cnt_d = cnt_q + W'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/cycle_window_ctrl.sv
// Measurement window sequencer: latches the cycle config on LOAD, holds
// window_active for that many cycles while counting events, then publishes
// the count and overflow flag. All outputs come from flops or the state reg.
module cycle_window_ctrl
  import cycle_ctrl_pkg::*;
#(
  parameter int CNT_W = cycle_ctrl_pkg::CNT_W,
  parameter int EVT_W = cycle_ctrl_pkg::EVT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cycle_cfg,
  input  logic             start,
  input  logic             abort,
  input  logic             cont_mode,
  input  logic             event_in,
  output logic             busy,
  output logic             window_active,
  output logic             done,
  output logic             overflow,
  cycle_window_ctrl_if.slave rd
);

  cyc_state_e       state_q, state_d;
  // remaining_q doubles as the latched window length: loaded from cycle_cfg
  // in LOAD and only decremented afterwards.
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [EVT_W-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic [EVT_W-1:0] rdata_q, rdata_d;
  logic             ready_q, ready_d;

  logic             cnt_clr, cnt_en;
  logic [EVT_W-1:0] evt_cnt;
  logic             ovf_live;

  sat_counter #(.W(EVT_W)) u_evt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (evt_cnt),
    .sat   (ovf_live)
  );

  // Sequencer next-state, window countdown and result capture.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        cnt_clr = 1'b1;
        if (cycle_cfg == '0) begin
          state_d = DONE;
        end else begin
          state_d     = RUN;
          remaining_d = cycle_cfg;
        end
      end
      RUN: begin
        cnt_en      = event_in;
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        result_d   = evt_cnt;
        overflow_d = ovf_live;
        state_d    = cont_mode ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort cancels everything, including a pending result publish.
    if (abort) begin
      state_d    = IDLE;
      result_d   = result_q;
      overflow_d = overflow_q;
      cnt_en     = 1'b0;
    end
  end

  // Registered read port: data is zero whenever no read is requested.
  always_comb begin
    rdata_d = rd.result_ren ? result_q : '0;
    ready_d = rd.result_ren;
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign window_active   = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign overflow        = overflow_q;
  assign rd.result_rdata = rdata_q;
  assign rd.result_ready = ready_q;

endmodule

// File: tb/tb_cycle_window_ctrl.sv
// Directed bench: a default-width instance and a 4-bit event counter instance
// share the same stimulus so saturation can be exercised at a small count.
module tb_cycle_window_ctrl;
  import cycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] cycle_cfg = '0;
  logic        start = 1'b0, abort = 1'b0, cont_mode = 1'b0, event_in = 1'b0;
  logic        ren = 1'b0;
  logic        busy, wa, done, ovf;
  logic        busy4, wa4, done4, ovf4;
  int          chk = 0, pass = 0;

  cycle_window_ctrl_if #(.EVT_W(16)) if16 ();
  cycle_window_ctrl_if #(.EVT_W(4))  if4 ();
  assign if16.result_ren = ren;
  assign if4.result_ren  = ren;

  always #5 clk = ~clk;

  cycle_window_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cycle_cfg(cycle_cfg), .start(start), .abort(abort),
    .cont_mode(cont_mode), .event_in(event_in), .busy(busy), .window_active(wa),
    .done(done), .overflow(ovf), .rd(if16.slave)
  );

  cycle_window_ctrl #(.CNT_W(11), .EVT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cycle_cfg(cycle_cfg), .start(start), .abort(abort),
    .cont_mode(cont_mode), .event_in(event_in), .busy(busy4), .window_active(wa4),
    .done(done4), .overflow(ovf4), .rd(if4.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      cyc();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    chk++; if ({busy, wa, done, ovf} !== 4'b0) $display("FAIL reset_outs got %b exp 0000", {busy, wa, done, ovf}); else pass++;
    chk++; if ({busy4, wa4, done4, ovf4} !== 4'b0) $display("FAIL reset_outs4 got %b exp 0000", {busy4, wa4, done4, ovf4}); else pass++;
    chk++; if ({if16.result_ready, if16.result_rdata} !== 17'h0) $display("FAIL reset_rd got %b/%h exp 0/0", if16.result_ready, if16.result_rdata); else pass++;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    logic [4:0] pat;
    pat = 5'b01101;  // bit i = event in RUN cycle i -> 3 events
    cycle_cfg = 11'd5;
    start = 1'b1;
    cyc();  // LOAD
    start = 1'b0;
    chk++; if ({busy, wa} !== 2'b10) $display("FAIL basic_load got %b exp 10", {busy, wa}); else pass++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk++; if (wa !== 1'b1) $display("FAIL basic_wa%0d got %b exp 1", i, wa); else pass++;
      event_in = pat[i];
    end
    cyc();  // DONE, N+7
    event_in = 1'b0;
    chk++; if ({done, wa} !== 2'b10) $display("FAIL basic_done got %b exp 10", {done, wa}); else pass++;
    ren = 1'b1;  // read during DONE sees previous result
    cyc();
    chk++; if ({done, busy} !== 2'b00) $display("FAIL basic_idle got %b exp 00", {done, busy}); else pass++;
    chk++; if ({if16.result_ready, if16.result_rdata} !== {1'b1, 16'd0}) $display("FAIL basic_oldrd got %b/%0d exp 1/0", if16.result_ready, if16.result_rdata); else pass++;
    cyc();
    ren = 1'b0;
    chk++; if ({if16.result_ready, if16.result_rdata} !== {1'b1, 16'd3}) $display("FAIL basic_rd got %b/%0d exp 1/3", if16.result_ready, if16.result_rdata); else pass++;
    chk++; if (if4.result_rdata !== 4'd3) $display("FAIL basic_rd4 got %0d exp 3", if4.result_rdata); else pass++;
    chk++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %b exp 0", ovf); else pass++;
    cyc();
    chk++; if ({if16.result_ready, if16.result_rdata} !== 17'h0) $display("FAIL basic_rdoff got %b/%0d exp 0/0", if16.result_ready, if16.result_rdata); else pass++;
  endtask

  task automatic test_empty();
    cycle_cfg = 11'd0;
    start = 1'b1;
    cyc();  // LOAD
    start = 1'b0;
    chk++; if ({busy, wa, done} !== 3'b100) $display("FAIL empty_load got %b exp 100", {busy, wa, done}); else pass++;
    cyc();  // DONE at N+2
    chk++; if ({wa, done} !== 2'b01) $display("FAIL empty_done got %b exp 01", {wa, done}); else pass++;
    cyc();
    ren = 1'b1;
    cyc();
    ren = 1'b0;
    chk++; if ({if16.result_ready, if16.result_rdata} !== {1'b1, 16'd0}) $display("FAIL empty_rd got %b/%0d exp 1/0", if16.result_ready, if16.result_rdata); else pass++;
    cyc();
  endtask

  task automatic test_back_to_back();
    cont_mode = 1'b1;
    cycle_cfg = 11'd4;
    start = 1'b1;
    cyc();  // LOAD
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk++; if (wa !== 1'b1) $display("FAIL b2b_wa1_%0d got %b exp 1", i, wa); else pass++;
      if (i == 1) cycle_cfg = 11'd2;
    end
    cyc();
    chk++; if ({done, wa} !== 2'b10) $display("FAIL b2b_done1 got %b exp 10", {done, wa}); else pass++;
    cyc();
    chk++; if ({busy, wa, done} !== 3'b100) $display("FAIL b2b_load2 got %b exp 100", {busy, wa, done}); else pass++;
    cont_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk++; if (wa !== 1'b1) $display("FAIL b2b_wa2_%0d got %b exp 1", i, wa); else pass++;
    end
    cyc();
    chk++; if ({done, wa} !== 2'b10) $display("FAIL b2b_done2 got %b exp 10", {done, wa}); else pass++;
    cyc();
    chk++; if (busy !== 1'b0) $display("FAIL b2b_idle got %b exp 0", busy); else pass++;
  endtask

  task automatic test_saturate();
    bit ok;
    cycle_cfg = 11'd20;
    event_in = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(40, ok);
    event_in = 1'b0;
    chk++; if (ok !== 1'b1) $display("FAIL sat_timeout got %b exp 1", ok); else pass++;
    cyc();
    chk++; if ({ovf4, ovf} !== 2'b10) $display("FAIL sat_ovf got %b exp 10", {ovf4, ovf}); else pass++;
    ren = 1'b1;
    cyc();
    ren = 1'b0;
    chk++; if (if4.result_rdata !== 4'd15) $display("FAIL sat_rd4 got %0d exp 15", if4.result_rdata); else pass++;
    chk++; if (if16.result_rdata !== 16'd20) $display("FAIL sat_rd16 got %0d exp 20", if16.result_rdata); else pass++;
    cycle_cfg = 11'd5;
    start = 1'b1;
    cyc();  // LOAD
    start = 1'b0;
    cyc();  // RUN1
    event_in = 1'b1;
    cyc();  // RUN2
    cyc();  // RUN3
    event_in = 1'b0;
    wait_done(10, ok);
    chk++; if (ok !== 1'b1) $display("FAIL sat2_timeout got %b exp 1", ok); else pass++;
    cyc();
    chk++; if (ovf4 !== 1'b0) $display("FAIL sat2_ovf got %b exp 0", ovf4); else pass++;
    ren = 1'b1;
    cyc();
    ren = 1'b0;
    chk++; if (if4.result_rdata !== 4'd2) $display("FAIL sat2_rd4 got %0d exp 2", if4.result_rdata); else pass++;
  endtask

  task automatic test_abort();
    bit ok, saw;
    cycle_cfg = 11'd7;
    event_in = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(20, ok);
    event_in = 1'b0;
    chk++; if (ok !== 1'b1) $display("FAIL abort_pre_timeout got %b exp 1", ok); else pass++;
    cyc();
    cycle_cfg = 11'd10;
    event_in = 1'b1;
    start = 1'b1;
    cyc();  // LOAD
    start = 1'b0;
    cyc(); cyc(); cyc();  // RUN3
    chk++; if (wa !== 1'b1) $display("FAIL abort_run3 got %b exp 1", wa); else pass++;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    event_in = 1'b0;
    chk++; if ({busy, wa, done} !== 3'b000) $display("FAIL abort_idle got %b exp 000", {busy, wa, done}); else pass++;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (done || busy) saw = 1'b1;
    end
    chk++; if (saw !== 1'b0) $display("FAIL abort_nodone got %b exp 0", saw); else pass++;
    ren = 1'b1;
    cyc();
    ren = 1'b0;
    chk++; if ({if16.result_ready, if16.result_rdata} !== {1'b1, 16'd7}) $display("FAIL abort_rd got %b/%0d exp 1/7", if16.result_ready, if16.result_rdata); else pass++;
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk++; if (busy !== 1'b0) $display("FAIL abort_start_same got %b exp 0", busy); else pass++;
    cyc();
    chk++; if (busy !== 1'b0) $display("FAIL abort_start_after got %b exp 0", busy); else pass++;
  endtask

  task automatic test_reset_mid();
    cycle_cfg = 11'd10;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();  // RUN2
    ren = 1'b1;
    cyc();
    chk++; if ({wa, if16.result_ready, if16.result_rdata} !== {2'b11, 16'd7}) $display("FAIL rstmid_pre got %b/%b/%0d exp 1/1/7", wa, if16.result_ready, if16.result_rdata); else pass++;
    #2;
    rst_n = 1'b0;
    #1;
    chk++; if ({busy, wa, done, if16.result_ready} !== 4'b0) $display("FAIL rstmid_async got %b exp 0000", {busy, wa, done, if16.result_ready}); else pass++;
    chk++; if (if16.result_rdata !== 16'd0) $display("FAIL rstmid_rdata got %0d exp 0", if16.result_rdata); else pass++;
    ren = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk++; if ({busy, if16.result_ready} !== 2'b00) $display("FAIL rstmid_idle got %b exp 00", {busy, if16.result_ready}); else pass++;
    ren = 1'b1;
    cyc();
    ren = 1'b0;
    chk++; if ({if16.result_ready, if16.result_rdata} !== {1'b1, 16'd0}) $display("FAIL rstmid_rd got %b/%0d exp 1/0", if16.result_ready, if16.result_rdata); else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_back_to_back();
    test_saturate();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
